// File: rtl/util_reset_sequencer.sv
// Ordered multi-domain reset release with per-stage ack, timeout/retry and a sticky fail flag.
// Optional feature: define UTIL_RST_SEQ_LOCK_MONITOR_EN to re-sequence when any ack drops in DONE.
module util_reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CNT    = 2000,
    parameter int ACK_TIMEOUT = 100000,
    parameter int MAX_RETRY   = 3,
    localparam int IDX_W      = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sw_rst,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  seq_done,
    output logic                  seq_fail,
    output logic [IDX_W-1:0]      cur_stage,
    output logic [7:0]            retry_cnt
);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_WAIT_ACK,
        ST_DONE,
        ST_FAIL
    } state_t;

    localparam logic [31:0]      HOLD_LAST = 32'(HOLD_CNT - 1);
    localparam logic [31:0]      TO_LAST   = 32'(ACK_TIMEOUT - 1);
    localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRY);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

    state_t                state, state_nxt;
    logic [31:0]           cnt, cnt_nxt;
    logic [NUM_STAGES-1:0] ack_meta, ack_s;
    logic [NUM_STAGES-1:0] rst_nxt;
    logic [NUM_STAGES-1:0] low_mask;
    logic                  lower_drop;
    logic                  done_nxt, fail_nxt;
    logic [IDX_W-1:0]      stage_nxt;
    logic [7:0]            retry_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_meta  <= '0;
            ack_s     <= '0;
            state     <= ST_ASSERT;
            cnt       <= '0;
            stage_rst <= '1;
            seq_done  <= 1'b0;
            seq_fail  <= 1'b0;
            cur_stage <= '0;
            retry_cnt <= '0;
        end else begin
            ack_meta  <= stage_ack;
            ack_s     <= ack_meta;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            stage_rst <= rst_nxt;
            seq_done  <= done_nxt;
            seq_fail  <= fail_nxt;
            cur_stage <= stage_nxt;
            retry_cnt <= retry_nxt;
        end
    end

    // Every released stage below the current one must keep its ack, else the sequence restarts.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
        rst_nxt    = stage_rst;
        done_nxt   = seq_done;
        fail_nxt   = seq_fail;
        stage_nxt  = cur_stage;
        retry_nxt  = retry_cnt;
        low_mask   = (NUM_STAGES'(1) << cur_stage) - NUM_STAGES'(1);
        lower_drop = |(low_mask & ~ack_s);

        if (sw_rst) begin
            state_nxt = ST_ASSERT;
            cnt_nxt   = '0;
            rst_nxt   = '1;
            done_nxt  = 1'b0;
            fail_nxt  = 1'b0;
            stage_nxt = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    rst_nxt   = '1;
                    stage_nxt = '0;
                    done_nxt  = 1'b0;
                    fail_nxt  = 1'b0;
                    if (cnt == HOLD_LAST) begin
                        state_nxt = ST_WAIT_ACK;
                        cnt_nxt   = '0;
                        rst_nxt   = {{(NUM_STAGES-1){1'b1}}, 1'b0};
                    end
                end
                ST_WAIT_ACK: begin
                    // An ack arriving on the timeout cycle wins over the timeout.
                    if (lower_drop || (!ack_s[cur_stage] && cnt == TO_LAST)) begin
                        cnt_nxt = '0;
                        rst_nxt = '1;
                        if (retry_cnt < RETRY_MAX) begin
                            state_nxt = ST_ASSERT;
                            stage_nxt = '0;
                            retry_nxt = retry_cnt + 8'd1;
                        end else begin
                            state_nxt = ST_FAIL;
                            fail_nxt  = 1'b1;
                        end
                    end else if (ack_s[cur_stage]) begin
                        cnt_nxt = '0;
                        if (cur_stage == LAST_IDX) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                            rst_nxt   = '0;
                        end else begin
                            stage_nxt = cur_stage + IDX_W'(1);
                            rst_nxt   = {stage_rst[NUM_STAGES-2:0], 1'b0};
                        end
                    end
                end
                ST_DONE: begin
`ifdef UTIL_RST_SEQ_LOCK_MONITOR_EN
                    if (!(&ack_s)) begin
                        state_nxt = ST_ASSERT;
                        cnt_nxt   = '0;
                        rst_nxt   = '1;
                        done_nxt  = 1'b0;
                        stage_nxt = '0;
                        retry_nxt = '0;
                    end
`else
                    done_nxt = 1'b1;
`endif
                end
                ST_FAIL: begin
                    fail_nxt = 1'b1;
                end
                default: begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                    rst_nxt   = '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_util_reset_sequencer.sv
// Directed self-checking bench for util_reset_sequencer (3 stages, hold 4, timeout 8, 1 retry).
// Models each domain as raising its ack 3 cycles after its reset falls, gated by ack_en.
module tb_util_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_rst;
    logic [2:0] stage_ack;
    logic [2:0] stage_rst;
    logic       seq_done;
    logic       seq_fail;
    logic [1:0] cur_stage;
    logic [7:0] retry_cnt;

    logic [2:0] ack_en;
    int         ack_cnt [3];
    int         checks = 0;
    int         errors = 0;

    util_reset_sequencer #(
        .NUM_STAGES (3),
        .HOLD_CNT   (4),
        .ACK_TIMEOUT(8),
        .MAX_RETRY  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_rst   (sw_rst),
        .stage_ack(stage_ack),
        .stage_rst(stage_rst),
        .seq_done (seq_done),
        .seq_fail (seq_fail),
        .cur_stage(cur_stage),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    // Domain model: ack asserts once its reset has been low for 3 cycles.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (stage_rst[i] !== 1'b0) ack_cnt[i] = 0;
            else if (ack_cnt[i] < 15) ack_cnt[i] = ack_cnt[i] + 1;
            stage_ack[i] = ack_en[i] && (ack_cnt[i] >= 3);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic [2:0] en);
        rst    = r;
        sw_rst = s;
        ack_en = en;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic resetDut(input logic [2:0] en);
        applyStimulus(1'b1, 1'b0, en);
        stepCycles(2);
        applyStimulus(1'b0, 1'b0, en);
    endtask

    task automatic waitDone();
        for (int k = 0; k < 100 && seq_done !== 1'b1; k++) stepCycles(1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) ack_cnt[i] = 0;
        stage_ack = 3'b000;

        // 1: clean sequence
        resetDut(3'b111);
        checkOutput("rst_stage_rst", 32'(stage_rst), 32'h7);
        checkOutput("rst_seq_done", 32'(seq_done), 32'h0);
        checkOutput("rst_seq_fail", 32'(seq_fail), 32'h0);
        checkOutput("rst_cur_stage", 32'(cur_stage), 32'h0);
        checkOutput("rst_retry_cnt", 32'(retry_cnt), 32'h0);
        stepCycles(3);
        checkOutput("hold_still_111", 32'(stage_rst), 32'h7);
        stepCycles(1);
        checkOutput("first_fall_110", 32'(stage_rst), 32'h6);
        for (int k = 0; k < 50 && stage_rst == 3'b110; k++) stepCycles(1);
        checkOutput("second_fall_100", 32'(stage_rst), 32'h4);
        checkOutput("cur_stage_1", 32'(cur_stage), 32'h1);
        for (int k = 0; k < 50 && stage_rst == 3'b100; k++) stepCycles(1);
        checkOutput("third_fall_000", 32'(stage_rst), 32'h0);
        waitDone();
        checkOutput("t1_seq_done", 32'(seq_done), 32'h1);
        checkOutput("t1_retry_cnt", 32'(retry_cnt), 32'h0);
        checkOutput("t1_seq_fail", 32'(seq_fail), 32'h0);
        checkOutput("t1_cur_stage", 32'(cur_stage), 32'h2);

        // 2: stage 1 never acks -> retry then fail
        resetDut(3'b101);
        for (int k = 0; k < 50 && stage_rst != 3'b100; k++) stepCycles(1);
        checkOutput("t2_reach_100", 32'(stage_rst), 32'h4);
        stepCycles(7);
        checkOutput("t2_pre_timeout", 32'(stage_rst), 32'h4);
        stepCycles(1);
        checkOutput("t2_timeout_111", 32'(stage_rst), 32'h7);
        checkOutput("t2_retry_1", 32'(retry_cnt), 32'h1);
        for (int k = 0; k < 100 && seq_fail !== 1'b1; k++) stepCycles(1);
        checkOutput("t2_seq_fail", 32'(seq_fail), 32'h1);
        checkOutput("t2_cur_stage", 32'(cur_stage), 32'h1);
        checkOutput("t2_stage_rst", 32'(stage_rst), 32'h7);
        checkOutput("t2_seq_done", 32'(seq_done), 32'h0);
        stepCycles(5);
        checkOutput("t2_fail_sticky", 32'(seq_fail), 32'h1);

        // 6: rst while in FAIL, then a normal run
        resetDut(3'b111);
        checkOutput("t6_fail_clr", 32'(seq_fail), 32'h0);
        checkOutput("t6_retry_clr", 32'(retry_cnt), 32'h0);
        checkOutput("t6_stage_rst", 32'(stage_rst), 32'h7);
        waitDone();
        checkOutput("t6_seq_done", 32'(seq_done), 32'h1);
        checkOutput("t6_retry_cnt", 32'(retry_cnt), 32'h0);

        // 3: stage 1 absent on first pass only
        resetDut(3'b101);
        for (int k = 0; k < 50 && retry_cnt != 8'd1; k++) stepCycles(1);
        applyStimulus(1'b0, 1'b0, 3'b111);
        waitDone();
        checkOutput("t3_seq_done", 32'(seq_done), 32'h1);
        checkOutput("t3_retry_cnt", 32'(retry_cnt), 32'h1);
        checkOutput("t3_seq_fail", 32'(seq_fail), 32'h0);

        // 4: sw_rst in WAIT_ACK(2) on the retry pass
        resetDut(3'b011);
        for (int k = 0; k < 50 && retry_cnt != 8'd1; k++) stepCycles(1);
        for (int k = 0; k < 50 && stage_rst != 3'b000; k++) stepCycles(1);
        checkOutput("t4_in_wait2", 32'(cur_stage), 32'h2);
        applyStimulus(1'b0, 1'b1, 3'b011);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 3'b111);
        checkOutput("t4_stage_rst", 32'(stage_rst), 32'h7);
        checkOutput("t4_retry_clr", 32'(retry_cnt), 32'h0);
        checkOutput("t4_cur_stage", 32'(cur_stage), 32'h0);
        stepCycles(3);
        checkOutput("t4_hold_111", 32'(stage_rst), 32'h7);
        stepCycles(1);
        checkOutput("t4_fall_110", 32'(stage_rst), 32'h6);

        // 5: drop ack 0 while in DONE
        resetDut(3'b111);
        waitDone();
        checkOutput("t5_done_before", 32'(seq_done), 32'h1);
        applyStimulus(1'b0, 1'b0, 3'b110);
        stepCycles(5);
`ifdef UTIL_RST_SEQ_LOCK_MONITOR_EN
        checkOutput("t5_mon_done_clr", 32'(seq_done), 32'h0);
        checkOutput("t5_mon_stage_rst", 32'(stage_rst), 32'h7);
        checkOutput("t5_mon_retry", 32'(retry_cnt), 32'h0);
        applyStimulus(1'b0, 1'b0, 3'b111);
        waitDone();
        checkOutput("t5_mon_redone", 32'(seq_done), 32'h1);
`else
        checkOutput("t5_done_kept", 32'(seq_done), 32'h1);
        checkOutput("t5_stage_rst_kept", 32'(stage_rst), 32'h0);
        checkOutput("t5_cur_stage_kept", 32'(cur_stage), 32'h2);
        applyStimulus(1'b0, 1'b0, 3'b111);
`endif
        checkOutput("t5_not_both", 32'(seq_done & seq_fail), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
